uart_rx_pin: RTL
================

// Module: uart_rx_pin
// PURPOSE
//  Serial receiver for the tt_um_main pin interface. It is the far end of the host link: the host
//  or bench drives 8N1 UART frames onto one ui_in bit, and this block recovers the bytes.
//  It presents each byte to core logic through a valid/ready handshake and reports framing and
//  overrun errors. It sits between the ui_in pad wiring and the command logic inside tt_um_main.
// PARAMETERS
//  CLKS_PER_BIT  16  clk cycles per UART bit; even, >= 8
//  SYNC_STAGES   2   flops in the rx metastability synchroniser; >= 2
// PORTS
//  clk          in   1  system clock; all logic rises on posedge
//  rst_n        in   1  asynchronous active-low reset
//  ena          in   1  design-selected enable from the TT harness
//  rx_i         in   1  serial line from ui_in; idles high
//  data_o       out  8  received byte; stable while valid_o=1
//  valid_o      out  1  data_o holds an unconsumed byte
//  ready_i      in   1  consumer accepts data_o when valid_o & ready_i
//  frame_err_o  out  1  one-cycle pulse: stop bit sampled low
//  overrun_o    out  1  sticky: a byte completed while valid_o was still 1
//  busy_o       out  1  FSM is not in IDLE
// BEHAVIOUR
//  - Reset: one clock; reset is asynchronous and active-low (rst_n). While rst_n=0:
//    data_o=0x00, valid_o=0, frame_err_o=0, overrun_o=0, busy_o=0, FSM=IDLE,
//    counters=0, synchroniser flops=1.
//  - rx_i passes through SYNC_STAGES flops. rxs denotes the synchronised value.
//  - FSM states:
//    IDLE: when ena=1 and rxs=1->0, load baud cnt=CLKS_PER_BIT/2-1 and go to START.
//    START: at cnt=0, sample rxs. 1 -> false start; return to IDLE with no output.
//      0 -> reload cnt=CLKS_PER_BIT-1, set bit idx=0, go to DATA.
//    DATA: at each cnt=0, shift rxs into the shift register (LSB first) and reload cnt.
//      After bit idx 7, go to STOP.
//    STOP: at cnt=0, sample rxs.
//      rxs=1: if valid_o=0 or ready_i=1 that cycle, load data_o and set valid_o=1 next cycle.
//        Otherwise keep old data_o, drop the new byte and set overrun_o=1. Go to IDLE.
//      rxs=0: pulse frame_err_o for 1 cycle, discard the byte, go to BREAK.
//    BREAK: wait until rxs=1, then go to IDLE. A held-low line never produces a new start.
//  - Baud cnt decrements each cycle outside IDLE and reloads on reaching 0.
//  - Timing: with the rx_i falling edge launched at cycle 0, valid_o rises at cycle
//    SYNC_STAGES + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT + 1 (155 for the defaults).
//  - Handshake: valid_o clears the cycle after valid_o & ready_i. A completed byte in that same
//    cycle replaces data_o, keeps valid_o=1 and does not set overrun.
//  - overrun_o clears on the next valid_o & ready_i handshake.
//  - ena=0 forces IDLE synchronously and resets the counters. data_o, valid_o and overrun_o hold.
//  - ena=0 mid-frame aborts the frame silently, with no error pulse.
//  - rst_n asserted mid-frame aborts immediately. After release, the first falling edge
//    starts a fresh frame.
// TESTING
//  (CLKS_PER_BIT=16, ena=1, ready_i=1 unless stated)
//  1. Send 0xA5 8N1 -> valid_o=1 at cycle 155 for exactly 1 cycle, data_o=0xA5, errors 0.
//  2. rx_i low for 4 cycles then high -> busy_o=1 then back to 0, no valid_o, no frame_err_o.
//  3. Send 0x3C with stop bit=0, then line high -> frame_err_o pulses once, valid_o stays 0.
//     A following 0x55 is then received correctly.
//  4. ready_i=0; send 0x11 then 0x22 -> data_o=0x11, overrun_o=1.
//     Pulse ready_i -> valid_o=0 and overrun_o=0.
//  5. Pull rst_n low during bit 4 of 0xF0 -> all outputs 0 asynchronously.
//     After release, 0x0F is received intact.
//  6. Back-to-back 0x00, 0xFF, 0x81 with no idle gap -> three valid pulses, in order, no errors.

Source files
------------

// File: rtl/uart_rx_pin.sv
// 8N1 UART receiver with an rx synchroniser and a mid-bit sampling FSM.
// Received bytes go to core logic through valid/ready, with framing and overrun reporting.
module uart_rx_pin #(
  parameter int CLKS_PER_BIT = 16,
  parameter int SYNC_STAGES  = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       rx_i,
  output logic [7:0] data_o,
  output logic       valid_o,
  input  logic       ready_i,
  output logic       frame_err_o,
  output logic       overrun_o,
  output logic       busy_o
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] START = 3'd1;
  localparam logic [2:0] DATA  = 3'd2;
  localparam logic [2:0] STOP  = 3'd3;
  localparam logic [2:0] BRK   = 3'd4;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rxs;
  logic                   rxs_prev;
  logic [2:0]             state;
  logic [CW-1:0]          cnt;
  logic [2:0]             bit_idx;
  logic [7:0]             shift_q;

  assign rxs    = sync_q[SYNC_STAGES-1];
  assign busy_o = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q   <= '1;
      rxs_prev <= 1'b1;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], rx_i};
      rxs_prev <= rxs;
    end
  end

  // Handshake: a byte is transferred in any cycle where valid_o & ready_i; valid_o drops
  // the next cycle unless a new byte completes in that same cycle and takes its place.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      bit_idx     <= '0;
      shift_q     <= '0;
      data_o      <= '0;
      valid_o     <= 1'b0;
      frame_err_o <= 1'b0;
      overrun_o   <= 1'b0;
    end else begin
      frame_err_o <= 1'b0;
      if (valid_o && ready_i) begin
        valid_o   <= 1'b0;
        overrun_o <= 1'b0;
      end
      if (!ena) begin
        state   <= IDLE;
        cnt     <= '0;
        bit_idx <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (rxs_prev && !rxs) begin
              cnt   <= HALF_M1;
              state <= START;
            end
          end
          START: begin
            if (cnt == '0) begin
              if (rxs) begin
                state <= IDLE;
              end else begin
                cnt     <= FULL_M1;
                bit_idx <= '0;
                state   <= DATA;
              end
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
          DATA: begin
            if (cnt == '0) begin
              shift_q <= {rxs, shift_q[7:1]};
              cnt     <= FULL_M1;
              if (bit_idx == 3'd7) state <= STOP;
              else bit_idx <= bit_idx + 1'b1;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
          STOP: begin
            if (cnt == '0) begin
              cnt <= FULL_M1;
              if (rxs) begin
                if (!valid_o || ready_i) begin
                  data_o  <= shift_q;
                  valid_o <= 1'b1;
                end else begin
                  overrun_o <= 1'b1;
                end
                state <= IDLE;
              end else begin
                frame_err_o <= 1'b1;
                state       <= BRK;
              end
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
          BRK: begin
            // A line held low must return high before a new start can be recognised.
            cnt <= (cnt == '0) ? FULL_M1 : cnt - 1'b1;
            if (rxs) state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
